hough_peak_scan: RTL and testbench

//  Downstream of the Hough accumulator memory. On start, scans every (r, phi) cell of the vote array through a read port.

---
 rtl/hough_pkg.sv | 27 ++
 rtl/hough_peak_track.sv | 33 +++
 rtl/hough_peak_scan.sv | 139 +++++++++++++
 tb/tb_hough_peak_scan.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared types and default dimensions for the Hough peak scanner.
// Scan-state encoding and the per-lane peak record live here.
package hough_pkg;

    localparam int MSB_R     = 11;
    localparam int MSB_PHI   = 7;
    localparam int MSB_CNT   = 15;
    localparam int R_MAX     = 2047;
    localparam int PHI_MAX   = 179;
    localparam int PHI_SPLIT = 90;
    localparam logic [MSB_CNT:0] THRESH = 16'h0020;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        OUT
    } scan_state_t;

    typedef struct packed {
        logic               found;
        logic [MSB_R:0]     r;
        logic [MSB_PHI:0]   phi;
        logic [MSB_CNT:0]   cnt;
    } peak_t;

endpackage

// File: rtl/hough_peak_track.sv
// Strongest-cell tracker for one lane half.
// Keeps the first cell in scan order among equal counts.
module hough_peak_track
    import hough_pkg::*;
#(
    parameter logic [MSB_CNT:0] THRESH = hough_pkg::THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [MSB_R:0]   r,
    input  logic [MSB_PHI:0] phi,
    input  logic [MSB_CNT:0] cnt,
    output peak_t            peak
);

    logic take;

    // strictly greater keeps the earlier cell on ties
    assign take = in_valid && (cnt >= THRESH) &&
                  (!peak.found || (cnt > peak.cnt));

    // peak register: cleared on reset or new scan, loaded on a better cell
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            peak <= '0;
        end else if (take) begin
            peak <= '{found: 1'b1, r: r, phi: phi, cnt: cnt};
        end
    end

endmodule

// File: rtl/hough_peak_scan.sv
// Scans the Hough vote array and reports the strongest left and
// right lane cells through a valid/ready result handshake.
module hough_peak_scan
    import hough_pkg::*;
#(
    parameter int R_MAX     = hough_pkg::R_MAX,
    parameter int PHI_MAX   = hough_pkg::PHI_MAX,
    parameter int PHI_SPLIT = hough_pkg::PHI_SPLIT,
    parameter logic [MSB_CNT:0] THRESH = hough_pkg::THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             rd_en,
    output logic [MSB_R:0]   rd_r,
    output logic [MSB_PHI:0] rd_phi,
    input  logic [MSB_CNT:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             left_found,
    output logic [MSB_R:0]   left_r,
    output logic [MSB_PHI:0] left_phi,
    output logic [MSB_CNT:0] left_cnt,
    output logic             right_found,
    output logic [MSB_R:0]   right_r,
    output logic [MSB_PHI:0] right_phi,
    output logic [MSB_CNT:0] right_cnt,
    output logic             done
);

    localparam logic [MSB_R:0]   R_LAST   = (MSB_R + 1)'(R_MAX);
    localparam logic [MSB_PHI:0] PHI_LAST = (MSB_PHI + 1)'(PHI_MAX);
    localparam logic [MSB_PHI:0] PHI_HALF = (MSB_PHI + 1)'(PHI_SPLIT);

    scan_state_t      state;
    logic             valid_d;
    logic [MSB_R:0]   r_d;
    logic [MSB_PHI:0] phi_d;
    logic             clear;
    logic             left_in;
    logic             right_in;
    logic             last_addr;
    peak_t            left_pk;
    peak_t            right_pk;

    assign clear     = (state == IDLE) && start;
    assign last_addr = (rd_r == R_LAST) && (rd_phi == PHI_LAST);
    assign left_in   = valid_d && (phi_d < PHI_HALF);
    assign right_in  = valid_d && (phi_d >= PHI_HALF);
    assign done      = out_valid && out_ready;

    // scan sequencer: address counters, read pipeline, handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_r      <= '0;
            rd_phi    <= '0;
            valid_d   <= 1'b0;
            r_d       <= '0;
            phi_d     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    valid_d <= 1'b0;
                    if (start) begin
                        state  <= SCAN;
                        busy   <= 1'b1;
                        rd_en  <= 1'b1;
                        rd_r   <= '0;
                        rd_phi <= '0;
                    end
                end
                SCAN: begin
                    valid_d <= 1'b1;
                    r_d     <= rd_r;
                    phi_d   <= rd_phi;
                    if (last_addr) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else if (rd_phi == PHI_LAST) begin
                        rd_phi <= '0;
                        rd_r   <= rd_r + 1'b1;
                    end else begin
                        rd_phi <= rd_phi + 1'b1;
                    end
                end
                DRAIN: begin
                    valid_d   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hough_peak_track #(.THRESH(THRESH)) u_left (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (left_in),
        .r        (r_d),
        .phi      (phi_d),
        .cnt      (rd_data),
        .peak     (left_pk)
    );

    hough_peak_track #(.THRESH(THRESH)) u_right (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (right_in),
        .r        (r_d),
        .phi      (phi_d),
        .cnt      (rd_data),
        .peak     (right_pk)
    );

    assign left_found  = left_pk.found;
    assign left_r      = left_pk.r;
    assign left_phi    = left_pk.phi;
    assign left_cnt    = left_pk.cnt;
    assign right_found = right_pk.found;
    assign right_r     = right_pk.r;
    assign right_phi   = right_pk.phi;
    assign right_cnt   = right_pk.cnt;

endmodule

// File: tb/tb_hough_peak_scan.sv
// Randomized bench for hough_peak_scan on a 4x10 vote array.
// Expected peaks come from a plain scan-order model of the array.
module tb_hough_peak_scan;

    localparam int NR = 4;
    localparam int NP = 10;
    localparam int SPLIT = 5;
    localparam int TH = 4;
    localparam int SCAN_CYC = NR * NP + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        rd_en;
    logic [11:0] rd_r;
    logic [7:0]  rd_phi;
    logic [15:0] rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        left_found, right_found;
    logic [11:0] left_r, right_r;
    logic [7:0]  left_phi, right_phi;
    logic [15:0] left_cnt, right_cnt;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [NR*NP];

    int e_lf, e_lr, e_lp, e_lc;
    int e_rf, e_rr, e_rp, e_rc;

    hough_peak_scan #(
        .R_MAX(NR - 1), .PHI_MAX(NP - 1),
        .PHI_SPLIT(SPLIT), .THRESH(16'(TH))
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_r(rd_r), .rd_phi(rd_phi),
        .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready),
        .left_found(left_found), .left_r(left_r),
        .left_phi(left_phi), .left_cnt(left_cnt),
        .right_found(right_found), .right_r(right_r),
        .right_phi(right_phi), .right_cnt(right_cnt),
        .done(done)
    );

    always #5 clk = ~clk;

    // accumulator RAM model, one cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            if (rd_r < NR && rd_phi < NP)
                rd_data <= mem[int'(rd_r) * NP + int'(rd_phi)];
            else
                rd_data <= 16'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // continuous protocol checks
    always @(negedge clk) begin
        if (!reset) begin
            check("rd_r_max", 64'(rd_r <= NR - 1), 1);
            check("rd_phi_max", 64'(rd_phi <= NP - 1), 1);
            check("rd_en_scan", 64'(rd_en && !(busy && !out_valid)), 0);
            check("done_hs", 64'(done), 64'(out_valid && out_ready));
        end
    end

    task automatic fill(input int v);
        for (int i = 0; i < NR * NP; i++) mem[i] = 16'(v);
    endtask

    task automatic put(input int r, input int p, input int v);
        mem[r * NP + p] = 16'(v);
    endtask

    // best cell per half: first in scan order with strictly larger count
    task automatic model();
        e_lf = 0; e_lr = 0; e_lp = 0; e_lc = 0;
        e_rf = 0; e_rr = 0; e_rp = 0; e_rc = 0;
        for (int r = 0; r < NR; r++) begin
            for (int p = 0; p < NP; p++) begin
                int c;
                c = int'(mem[r * NP + p]);
                if (c >= TH) begin
                    if (p < SPLIT) begin
                        if (e_lf == 0 || c > e_lc) begin
                            e_lf = 1; e_lr = r; e_lp = p; e_lc = c;
                        end
                    end else begin
                        if (e_rf == 0 || c > e_rc) begin
                            e_rf = 1; e_rr = r; e_rp = p; e_rc = c;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_result(input string t);
        check({t, "_lf"}, 64'(left_found), 64'(e_lf));
        check({t, "_lr"}, 64'(left_r), 64'(e_lr));
        check({t, "_lp"}, 64'(left_phi), 64'(e_lp));
        check({t, "_lc"}, 64'(left_cnt), 64'(e_lc));
        check({t, "_rf"}, 64'(right_found), 64'(e_rf));
        check({t, "_rr"}, 64'(right_r), 64'(e_rr));
        check({t, "_rp"}, 64'(right_phi), 64'(e_rp));
        check({t, "_rc"}, 64'(right_cnt), 64'(e_rc));
    endtask

    // start, wait for out_valid, verify scan length and results
    task automatic scan(input string t);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({t, "_busy"}, 64'(busy), 1);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        check({t, "_len"}, 64'(n), 64'(SCAN_CYC));
        @(negedge clk);
        model();
        check_result(t);
    endtask

    // hold ready low for wait_cyc cycles with stray starts, then accept
    task automatic accept(input string t, input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            start = (i % 3 == 1);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check({t, "_hold_v"}, 64'(out_valid), 1);
            check({t, "_hold_d"}, 64'(done), 0);
            if (i == wait_cyc - 1) check_result({t, "_hold"});
        end
        out_ready = 1'b1;
        #1;
        check({t, "_done"}, 64'(done), 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({t, "_done0"}, 64'(done), 0);
        check({t, "_idle_b"}, 64'(busy), 0);
        check({t, "_idle_v"}, 64'(out_valid), 0);
        @(negedge clk);
        check_result({t, "_keep"});
    endtask

    initial begin
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_rden", 64'(rd_en), 0);
        check("rst_ov", 64'(out_valid), 0);
        check("rst_addr", 64'({rd_r, rd_phi}), 0);
        check("rst_done", 64'(done), 0);
        model();
        check_result("rst");
        @(negedge clk) reset = 1'b0;

        fill(0);
        scan("zero");
        accept("zero", 0);

        fill(1);
        put(2, 3, 7);
        put(1, 8, 9);
        scan("two");
        accept("two", 0);

        fill(0);
        put(0, 4, 6);
        put(3, 1, 6);
        scan("tie");
        accept("tie", 1);

        fill(0);
        put(1, 5, 3);
        put(2, 6, 4);
        scan("thr");
        accept("thr", 10);

        fill(2);
        put(0, 2, 16'hFFFF);
        put(3, 7, 16'hFFFF);
        put(1, 9, 16'hFFFE);
        scan("max");
        accept("max", 2);

        fill(0);
        put(2, 2, 5);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 0);
        check("abort_rden", 64'(rd_en), 0);
        check("abort_ov", 64'(out_valid), 0);
        check("abort_lf", 64'(left_found), 0);
        check("abort_rf", 64'(right_found), 0);
        @(negedge clk) reset = 1'b0;
        put(3, 8, 11);
        scan("fresh");
        accept("fresh", 0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR * NP; i++) begin
                if ($urandom_range(0, 19) == 0)
                    mem[i] = 16'hFFFF;
                else
                    mem[i] = 16'($urandom_range(0, 9));
            end
            scan("rnd");
            accept("rnd", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
